// File: rtl/axi_fifo_pkg.sv
// Shared types and constants for the AXI write-to-FIFO bridge.
package axi_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi_fifo_wr_bridge.sv
// AXI write slave that streams W beats into an external byte FIFO and returns a B response.
// Burst length mismatches against wlast are reported as SLVERR.
module axi_fifo_wr_bridge
  import axi_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [ID_W-1:0]   awid,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wlast,
  output logic              bvalid,
  input  logic              bready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              wr_rd,
  output logic [DATA_W-1:0] D_in,
  input  logic              full,
  output logic [15:0]       beats_pushed
);

  state_e          state_q;
  logic [7:0]      cnt_q;
  logic [7:0]      len_q;
  logic [ID_W-1:0] id_q;
  logic            err_q;
  logic [15:0]     beats_q;

  logic push;
  logic final_beat;
  logic beat_err;
  logic unused_addr;

  // Address is accepted but the FIFO has no address space.
  assign unused_addr = ^awaddr;

  assign push       = (state_q == DATA) & wvalid & ~full & ~rst;
  assign final_beat = (cnt_q == len_q);
  assign beat_err   = final_beat ? ~wlast : wlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      beats_q <= '0;
    end else begin
      if (push) begin
        beats_q <= beats_q + 16'd1;
      end
      unique case (state_q)
        IDLE: begin
          if (awvalid) begin
            state_q <= DATA;
            id_q    <= awid;
            len_q   <= awlen;
            cnt_q   <= '0;
            err_q   <= 1'b0;
          end
        end
        DATA: begin
          if (push) begin
            cnt_q <= cnt_q + 8'd1;
            // Fold the final beat's check in here so RESP can read err_q alone.
            err_q <= err_q | beat_err;
            if (final_beat) begin
              state_q <= RESP;
            end
          end
        end
        RESP: begin
          if (bready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    awready      = (state_q == IDLE) & ~rst;
    wready       = (state_q == DATA) & ~full & ~rst;
    bvalid       = (state_q == RESP) & ~rst;
    bid          = bvalid ? id_q : '0;
    bresp        = (bvalid && err_q) ? SLVERR : OKAY;
    wr_rd        = push;
    D_in         = push ? wdata : '0;
    beats_pushed = beats_q;
  end

endmodule

// File: tb/tb_axi_fifo_wr_bridge.sv
// Self-checking bench for axi_fifo_wr_bridge: directed vector table, wrap/reset sequences,
// and randomized bursts checked against a burst-level reference model.
module tb_axi_fifo_wr_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [3:0]  awid;
  logic        wvalid;
  logic        wready;
  logic [7:0]  wdata;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        wr_rd;
  logic [7:0]  D_in;
  logic        full;
  logic [15:0] beats_pushed;

  axi_fifo_wr_bridge #(
    .DATA_W(8),
    .ID_W  (4),
    .ADDR_W(32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .awvalid     (awvalid),
    .awready     (awready),
    .awaddr      (awaddr),
    .awlen       (awlen),
    .awid        (awid),
    .wvalid      (wvalid),
    .wready      (wready),
    .wdata       (wdata),
    .wlast       (wlast),
    .bvalid      (bvalid),
    .bready      (bready),
    .bid         (bid),
    .bresp       (bresp),
    .wr_rd       (wr_rd),
    .D_in        (D_in),
    .full        (full),
    .beats_pushed(beats_pushed)
  );

  always #5 clk = ~clk;

  localparam int MaxCyc = 2048;

  int n_cmp  = 0;
  int n_fail = 0;

  // Per-burst stimulus: beat payloads/wlast flags and per-cycle wvalid/full schedule.
  logic [7:0]  g_data[256];
  bit          g_wl[256];
  bit          g_wv[MaxCyc];
  bit          g_full[MaxCyc];
  logic [15:0] bp_exp;

  typedef struct {
    logic [3:0] id;
    int         len;
    int         last_pos;
    int         fs_start;
    int         fs_len;
    int         bdelay;
    logic [1:0] exp_resp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_bvalid"}, {31'd0, bvalid}, 32'd0);
    chk({name, "_wready"}, {31'd0, wready}, 32'd0);
    chk({name, "_wr_rd"},  {31'd0, wr_rd},  32'd0);
  endtask

  // Reference: a burst is in error iff wlast appears anywhere other than exactly the last beat.
  function automatic logic [1:0] model_resp(input int len);
    bit err = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if ((i < len && g_wl[i]) || (i == len && !g_wl[i])) err = 1'b1;
    end
    return err ? 2'b10 : 2'b00;
  endfunction

  function automatic void sched_dense();
    for (int c = 0; c < MaxCyc; c++) begin
      g_wv[c]   = 1'b1;
      g_full[c] = 1'b0;
    end
  endfunction

  function automatic void sched_random();
    for (int c = 0; c < MaxCyc; c++) begin
      g_wv[c]   = (c >= 600) || ($urandom_range(0, 99) < 80);
      g_full[c] = (c < 600) && ($urandom_range(0, 99) < 25);
    end
  endfunction

  // Drives one full AW/W/B transaction starting from IDLE at a negedge.
  task automatic run_burst(input logic [3:0] id, input int len, input int bdelay,
                           input logic [1:0] exp_resp, input string name);
    int         sent = 0;
    int         cyc  = 0;
    logic [7:0] got[$];
    bit         exp_push;

    awvalid = 1'b1;
    awid    = id;
    awlen   = len[7:0];
    awaddr  = $urandom;
    #1;
    chk({name, "_awready"}, {31'd0, awready}, 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    awid    = '0;

    while (sent <= len && cyc < MaxCyc) begin
      wvalid = g_wv[cyc];
      full   = g_full[cyc];
      wdata  = g_data[sent];
      wlast  = g_wl[sent];
      #1;
      exp_push = wvalid && !full;
      chk({name, "_wr_rd"},   {31'd0, wr_rd},   {31'd0, exp_push});
      chk({name, "_wready"},  {31'd0, wready},  {31'd0, !full});
      chk({name, "_d_awrdy"}, {31'd0, awready}, 32'd0);
      chk({name, "_d_bvld"},  {31'd0, bvalid},  32'd0);
      if (exp_push) begin
        chk({name, "_D_in"}, {24'd0, D_in}, {24'd0, wdata});
        got.push_back(D_in);
        sent++;
      end else begin
        chk({name, "_D_in_idle"}, {24'd0, D_in}, 32'd0);
      end
      @(negedge clk);
      cyc++;
    end
    chk({name, "_beats_sent"}, sent, len + 1);
    bp_exp = bp_exp + 16'(len + 1);

    // Stray W traffic during RESP must be ignored.
    full  = 1'b0;
    wlast = 1'b0;
    for (int i = 0; i <= bdelay; i++) begin
      wvalid = $urandom_range(0, 1) == 1;
      bready = (i == bdelay);
      #1;
      chk({name, "_bvalid"},   {31'd0, bvalid},  32'd1);
      chk({name, "_bid"},      {28'd0, bid},     {28'd0, id});
      chk({name, "_bresp"},    {30'd0, bresp},   {30'd0, exp_resp});
      chk({name, "_r_awrdy"},  {31'd0, awready}, 32'd0);
      chk({name, "_r_wready"}, {31'd0, wready},  32'd0);
      chk({name, "_r_wr_rd"},  {31'd0, wr_rd},   32'd0);
      @(negedge clk);
    end
    bready = 1'b0;
    wvalid = 1'b0;
    #1;
    chk({name, "_post_awrdy"}, {31'd0, awready}, 32'd1);
    chk({name, "_post_bvld"},  {31'd0, bvalid},  32'd0);
    chk({name, "_beats_pushed"}, {16'd0, beats_pushed}, {16'd0, bp_exp});
    for (int i = 0; i < got.size() && i <= len; i++) begin
      if (got[i] !== g_data[i]) chk({name, "_order"}, {24'd0, got[i]}, {24'd0, g_data[i]});
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_D_in",    {24'd0, D_in},    32'd0);
    chk("rst_bid",     {28'd0, bid},     32'd0);
    chk("rst_bresp",   {30'd0, bresp},   32'd0);
    chk_idle_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
    bp_exp = '0;
    #1;
    chk("rst_rel_awready", {31'd0, awready}, 32'd1);
    chk("rst_rel_beats",   {16'd0, beats_pushed}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    awvalid = 1'b0;
    awaddr  = '0;
    awlen   = '0;
    awid    = '0;
    wvalid  = 1'b0;
    wdata   = '0;
    wlast   = 1'b0;
    bready  = 1'b0;
    full    = 1'b0;
    bp_exp  = '0;

    vecs[0] = '{id: 4'h5, len: 3, last_pos: 3,  fs_start: 0, fs_len: 0, bdelay: 0,
                exp_resp: 2'b00};
    vecs[1] = '{id: 4'hA, len: 3, last_pos: 3,  fs_start: 2, fs_len: 3, bdelay: 1,
                exp_resp: 2'b00};
    vecs[2] = '{id: 4'h3, len: 2, last_pos: 1,  fs_start: 0, fs_len: 0, bdelay: 0,
                exp_resp: 2'b10};
    vecs[3] = '{id: 4'h9, len: 0, last_pos: -1, fs_start: 0, fs_len: 0, bdelay: 0,
                exp_resp: 2'b10};
    vecs[4] = '{id: 4'hF, len: 0, last_pos: 0,  fs_start: 0, fs_len: 0, bdelay: 5,
                exp_resp: 2'b00};
    vecs[5] = '{id: 4'h6, len: 3, last_pos: 3,  fs_start: 1, fs_len: 2, bdelay: 5,
                exp_resp: 2'b00};
    vecs[6] = '{id: 4'h1, len: 4, last_pos: 2,  fs_start: 3, fs_len: 1, bdelay: 2,
                exp_resp: 2'b10};

    repeat (2) @(negedge clk);
    do_reset();

    foreach (vecs[v]) begin
      sched_dense();
      for (int c = vecs[v].fs_start; c < vecs[v].fs_start + vecs[v].fs_len; c++) g_full[c] = 1'b1;
      for (int i = 0; i < 256; i++) begin
        g_data[i] = 8'((i + 1) * 8'h11);
        g_wl[i]   = (i == vecs[v].last_pos);
      end
      run_burst(vecs[v].id, vecs[v].len, vecs[v].bdelay, vecs[v].exp_resp, $sformatf("vec%0d", v));
    end

    // Reset during beat 3 of an 8-beat burst: no B response, next burst clean.
    awvalid = 1'b1;
    awlen   = 8'd7;
    awid    = 4'h4;
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_wr_rd",   {31'd0, wr_rd},   32'd0);
    chk("midrst_awready", {31'd0, awready}, 32'd0);
    chk("midrst_D_in",    {24'd0, D_in},    32'd0);
    @(negedge clk);
    rst    = 1'b0;
    wvalid = 1'b0;
    bp_exp = '0;
    #1;
    chk("midrst_beats", {16'd0, beats_pushed}, 32'd0);
    chk("midrst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("midrst_idle", {31'd0, awready}, 32'd1);
    @(negedge clk);
    sched_dense();
    g_data[0] = 8'h5A;
    g_wl[0]   = 1'b1;
    run_burst(4'h2, 0, 0, 2'b00, "post_rst");

    // Preload beats_pushed to 0xFFFE with max-length bursts, then wrap.
    do_reset();
    sched_dense();
    for (int i = 0; i < 256; i++) begin
      g_data[i] = 8'(i);
      g_wl[i]   = (i == 255);
    end
    for (int b = 0; b < 255; b++) run_burst(4'h7, 255, 0, 2'b00, "fill");
    for (int i = 0; i < 256; i++) g_wl[i] = (i == 253);
    run_burst(4'h7, 253, 0, 2'b00, "fill_tail");
    chk("preload_fffe", {16'd0, beats_pushed}, 32'h0000_FFFE);
    for (int i = 0; i < 256; i++) g_wl[i] = (i == 3);
    run_burst(4'h8, 3, 0, 2'b00, "wrap");
    chk("wrap_0002", {16'd0, beats_pushed}, 32'h0000_0002);

    // Randomized bursts against the burst-level model.
    for (int r = 0; r < 40; r++) begin
      int         len;
      logic [3:0] id;
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
      id  = 4'($urandom);
      for (int i = 0; i < 256; i++) begin
        g_data[i] = 8'($urandom);
        g_wl[i]   = (i == len);
      end
      if ($urandom_range(0, 3) == 0) begin
        int p;
        p = $urandom_range(0, len);
        g_wl[p] = ~g_wl[p];
      end
      sched_random();
      run_burst(id, len, $urandom_range(0, 4), model_resp(len), $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
